// File: rtl/bp_pkg.sv
// bp_pkg: shared mode constants and saturating-counter helpers for the two-level predictor.
package bp_pkg;
    localparam int BP_MODE_LOCAL  = 0;
    localparam int BP_MODE_GSHARE = 1;

    function automatic logic [3:0] weak_taken(input int ctrW);
        weak_taken = 4'(1 << (ctrW - 1));
    endfunction

    function automatic logic [3:0] sat_ctr_next(input logic [3:0] ctr, input logic taken, input int ctrW = 2);
        logic [3:0] maxVal;
        maxVal = 4'((1 << ctrW) - 1);
        sat_ctr_next = taken ? ((ctr == maxVal) ? ctr : ctr + 4'd1)
                             : ((ctr == 4'd0) ? ctr : ctr - 4'd1);
    endfunction
endpackage

// File: rtl/bp_pht.sv
// bp_pht: pattern history table of saturating counters, combinational read, synchronous update.
module bp_pht import bp_pkg::*; #(
    parameter int HIST_LEN = 6,
    parameter int CTR_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [HIST_LEN-1:0] rdIdx,
    output logic [CTR_W-1:0]    rdCtr,
    input  logic                updValid,
    input  logic [HIST_LEN-1:0] updIdx,
    input  logic                updTaken
);
    logic [CTR_W-1:0] ctrs [2**HIST_LEN];

    // No bypass: a same-cycle update to rdIdx is seen from the next cycle.
    assign rdCtr = ctrs[rdIdx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**HIST_LEN; i++) ctrs[i] <= CTR_W'(weak_taken(CTR_W));
        end else if (updValid) begin
            ctrs[updIdx] <= CTR_W'(sat_ctr_next(4'(ctrs[updIdx]), updTaken, CTR_W));
        end
    end
endmodule

// File: rtl/bp_two_level.sv
// bp_two_level: two-level branch predictor (PAg local history or gshare); lookup in IF, registered in ID, trained in MEM.
// Define BP_PERF_CNT_EN to implement the perf_lookups/perf_mispreds counters; otherwise they read 0.
module bp_two_level import bp_pkg::*; #(
    parameter int MODE      = BP_MODE_LOCAL,
    parameter int BHT_DEPTH = 10,
    parameter int HIST_LEN  = 6,
    parameter int CTR_W     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pcF,
    input  logic                stallD,
    input  logic                flushD,
    input  logic                is_branchD,
    output logic                pred_takeD,
    output logic [HIST_LEN-1:0] pred_idxD,
    output logic [HIST_LEN-1:0] pred_histD,
    input  logic                upd_validM,
    input  logic [31:0]         upd_pcM,
    input  logic                upd_takenM,
    input  logic                upd_mispredM,
    input  logic [HIST_LEN-1:0] upd_idxM,
    input  logic [HIST_LEN-1:0] upd_histM,
    output logic [31:0]         perf_lookups,
    output logic [31:0]         perf_mispreds
);
    logic [HIST_LEN-1:0] ghr, idxF, histF, idxD, histD;
    logic [CTR_W-1:0]    ctrF, ctrD;
    logic                unusedBits;

    bp_pht #(.HIST_LEN(HIST_LEN), .CTR_W(CTR_W)) uPht (
        .clk      (clk),
        .rst      (rst),
        .rdIdx    (idxF),
        .rdCtr    (ctrF),
        .updValid (upd_validM),
        .updIdx   (upd_idxM),
        .updTaken (upd_takenM)
    );

    generate
        if (MODE == BP_MODE_GSHARE) begin : g_gshare
            assign idxF  = ghr ^ pcF[HIST_LEN+1:2];
            assign histF = ghr;
            // Mispredict recovery wins over a same-cycle speculative shift.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ghr <= '0;
                end else if (upd_validM && upd_mispredM) begin
                    ghr <= {upd_histM[HIST_LEN-2:0], upd_takenM};
                end else if (is_branchD && !stallD && !flushD) begin
                    ghr <= {ghr[HIST_LEN-2:0], pred_takeD};
                end
            end
        end else begin : g_local
            logic [HIST_LEN-1:0] bht [2**BHT_DEPTH];
            assign histF = bht[pcF[BHT_DEPTH+1:2]];
            assign idxF  = histF;
            assign ghr   = '0;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < 2**BHT_DEPTH; i++) bht[i] <= '0;
                end else if (upd_validM) begin
                    bht[upd_pcM[BHT_DEPTH+1:2]] <= {upd_histM[HIST_LEN-2:0], upd_takenM};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || flushD) begin
            ctrD  <= '0;
            idxD  <= '0;
            histD <= '0;
        end else if (!stallD) begin
            ctrD  <= ctrF;
            idxD  <= idxF;
            histD <= histF;
        end
    end

    assign pred_takeD = is_branchD & ctrD[CTR_W-1];
    assign pred_idxD  = idxD;
    assign pred_histD = histD;

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_lookups  <= '0;
            perf_mispreds <= '0;
        end else if (upd_validM) begin
            perf_lookups  <= perf_lookups + 32'd1;
            perf_mispreds <= perf_mispreds + 32'(upd_mispredM);
        end
    end
`else
    assign perf_lookups  = '0;
    assign perf_mispreds = '0;
`endif

    assign unusedBits = ^{pcF, upd_pcM, upd_histM, upd_mispredM, ghr};
endmodule
